// File: rtl/devil_pkg.sv
// Shared encodings for the snoop-response injector: FSM states, mode/test
// codes and control-register bit positions.
package devil_pkg;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_PRE_DLY  = 4'd1,
        ST_CR       = 4'd2,
        ST_MID_DLY  = 4'd3,
        ST_CD       = 4'd4,
        ST_LAST_DLY = 4'd5,
        ST_END      = 4'd6
    } state_e;

    localparam logic [1:0] MODE_OSH   = 2'd0;
    localparam logic [1:0] MODE_NSHOT = 2'd1;
    localparam logic [1:0] MODE_CON   = 2'd2;
    localparam logic [1:0] MODE_RSVD  = 2'd3;

    localparam logic [2:0] TEST_NONE     = 3'd0;
    localparam logic [2:0] TEST_DLY_CR   = 3'd1;
    localparam logic [2:0] TEST_DLY_CD   = 3'd2;
    localparam logic [2:0] TEST_DLY_LAST = 3'd3;
    localparam logic [2:0] TEST_DLY_ALL  = 3'd4;

    // Low bit index of each control-register field
    localparam int CTRL_EN        = 0;
    localparam int CTRL_MODE      = 1;
    localparam int CTRL_TEST      = 3;
    localparam int CTRL_CRRESP    = 6;
    localparam int CTRL_ADDR_FLT  = 11;
    localparam int CTRL_SNP_FLT   = 12;
    localparam int CTRL_SNP_MATCH = 13;
    localparam int CTRL_CLR       = 17;

    localparam int DEFAULT_CYCLES_PER_US = 150;

endpackage

// File: rtl/devil_addr_window_match.sv
// Combinational OR of NUM_WINDOWS [base, base+size) address comparators.
// Bounds are widened by one bit so a window near the top never wraps to 0.
module devil_addr_window_match
    import devil_pkg::*;
#(
    parameter int AW          = 44,
    parameter int NUM_WINDOWS = 4
) (
    input  logic [AW-1:0]             addr_i,
    input  logic [NUM_WINDOWS*AW-1:0] base_flat_i,
    input  logic [NUM_WINDOWS*AW-1:0] size_flat_i,
    output logic                      match_o
);

    logic [NUM_WINDOWS-1:0] win_hit;

    for (genvar g = 0; g < NUM_WINDOWS; g++) begin : g_win
        logic [AW:0] base_ext;
        logic [AW:0] size_ext;
        logic [AW:0] end_ext;
        logic [AW:0] addr_ext;

        assign base_ext   = {1'b0, base_flat_i[g*AW +: AW]};
        assign size_ext   = {1'b0, size_flat_i[g*AW +: AW]};
        assign end_ext    = base_ext + size_ext;
        assign addr_ext   = {1'b0, addr_i};
        assign win_hit[g] = (size_ext != '0) && (addr_ext >= base_ext) && (addr_ext < end_ext);
    end

    assign match_o = |win_hit;

endmodule

// File: rtl/devil_snoop_injector.sv
// Takes over the ACE CR/CD snoop response for snoops that match the programmed
// address windows / snoop type, forging CRRESP and a CD burst with optional delays.
module devil_snoop_injector
    import devil_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_ACE_DATA_WIDTH   = 128,
    parameter int C_ACE_ADDR_WIDTH   = 44,
    parameter int NUM_WINDOWS        = 4,
    parameter int CD_BEATS           = 4,
    parameter int CYCLES_PER_US      = DEFAULT_CYCLES_PER_US
) (
    input  logic                                    ace_aclk,
    input  logic                                    ace_areset,
    input  logic                                    i_snoop_req,
    input  logic [C_ACE_ADDR_WIDTH-1:0]             i_acaddr,
    input  logic [3:0]                              i_acsnoop,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]           i_control_reg,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]           i_delay_reg,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]           i_count_reg,
    input  logic [31:0]                             i_payload_reg,
    input  logic [NUM_WINDOWS*C_ACE_ADDR_WIDTH-1:0] i_base_addr_flat,
    input  logic [NUM_WINDOWS*C_ACE_ADDR_WIDTH-1:0] i_addr_size_flat,
    output logic [C_S_AXI_DATA_WIDTH-1:0]           o_status_reg,
    output logic                                    o_hit,
    output logic [3:0]                              o_state,
    output logic [4:0]                              o_crresp,
    output logic                                    o_crvalid,
    input  logic                                    i_crready,
    output logic [C_ACE_DATA_WIDTH-1:0]             o_cddata,
    output logic                                    o_cdvalid,
    output logic                                    o_cdlast,
    input  logic                                    i_cdready
);

    localparam int            NW        = C_ACE_DATA_WIDTH / 32;
    localparam int            BW        = (CD_BEATS > 1) ? $clog2(CD_BEATS) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(CD_BEATS - 1);

    // Control decode (live values, used only for the hit decision and END)
    logic       ctrl_en, ctrl_addr_flt, ctrl_snp_flt, ctrl_clr;
    logic [1:0] ctrl_mode;
    logic [2:0] ctrl_test;
    logic [4:0] ctrl_crresp;
    logic [3:0] ctrl_snp_match;
    logic       ctrl_unused;

    assign ctrl_en        = i_control_reg[CTRL_EN];
    assign ctrl_mode      = i_control_reg[CTRL_MODE +: 2];
    assign ctrl_test      = i_control_reg[CTRL_TEST +: 3];
    assign ctrl_crresp    = i_control_reg[CTRL_CRRESP +: 5];
    assign ctrl_addr_flt  = i_control_reg[CTRL_ADDR_FLT];
    assign ctrl_snp_flt   = i_control_reg[CTRL_SNP_FLT];
    assign ctrl_snp_match = i_control_reg[CTRL_SNP_MATCH +: 4];
    assign ctrl_clr       = i_control_reg[CTRL_CLR];
    assign ctrl_unused    = ^i_control_reg[C_S_AXI_DATA_WIDTH-1:CTRL_CLR+1];

    state_e                          state_q, state_d;
    logic [63:0]                     dly_cnt_q, dly_cnt_d;
    logic [BW-1:0]                   beat_q, beat_d;
    logic [2:0]                      test_q;
    logic [4:0]                      crresp_q;
    logic [C_S_AXI_DATA_WIDTH-1:0]   delay_q;
    logic [31:0]                     payload_q;
    logic                            done_q;
    logic [15:0]                     cnt_q;

    logic        win_match, hit, pre_dly_in;
    logic        dly_zero, dly_done, need_mid_dly, need_last_dly;
    logic [63:0] dly_target;
    logic [31:0] beat_word;
    logic [15:0] cnt_inc;
    logic [C_S_AXI_DATA_WIDTH-1:0] nshot_n;
    logic        done_set;

    devil_addr_window_match #(
        .AW          (C_ACE_ADDR_WIDTH),
        .NUM_WINDOWS (NUM_WINDOWS)
    ) u_win (
        .addr_i      (i_acaddr),
        .base_flat_i (i_base_addr_flat),
        .size_flat_i (i_addr_size_flat),
        .match_o     (win_match)
    );

    // A clear in the same cycle as a snoop takes priority over the snoop
    assign hit = (state_q == ST_IDLE) && i_snoop_req && ctrl_en && (ctrl_mode != MODE_RSVD)
              && !done_q && !ctrl_clr
              && (!ctrl_addr_flt || win_match)
              && (!ctrl_snp_flt || (i_acsnoop == ctrl_snp_match));

    assign pre_dly_in    = ((ctrl_test == TEST_DLY_CR) || (ctrl_test == TEST_DLY_ALL))
                        && (i_delay_reg != '0);
    assign dly_zero      = (delay_q == '0);
    assign dly_target    = 64'(CYCLES_PER_US) * 64'(delay_q);
    assign dly_done      = (dly_cnt_q == dly_target - 64'd1);
    assign need_mid_dly  = ((test_q == TEST_DLY_CD) || (test_q == TEST_DLY_ALL)) && !dly_zero;
    assign need_last_dly = (test_q == TEST_DLY_LAST) && !dly_zero;
    assign beat_word     = payload_q + 32'(beat_q);

    always_comb begin
        state_d   = state_q;
        dly_cnt_d = dly_cnt_q;
        beat_d    = beat_q;
        o_crvalid = 1'b0;
        o_crresp  = '0;
        o_cdvalid = 1'b0;
        o_cdlast  = 1'b0;
        o_cddata  = '0;
        case (state_q)
            ST_IDLE: begin
                beat_d    = '0;
                dly_cnt_d = '0;
                if (hit) state_d = pre_dly_in ? ST_PRE_DLY : ST_CR;
            end
            ST_PRE_DLY: begin
                if (dly_done) begin
                    dly_cnt_d = '0;
                    state_d   = ST_CR;
                end else begin
                    dly_cnt_d = dly_cnt_q + 64'd1;
                end
            end
            ST_CR: begin
                o_crvalid = 1'b1;
                o_crresp  = crresp_q;
                if (i_crready) begin
                    if (!crresp_q[0])                           state_d = ST_END;
                    else if (need_mid_dly)                      state_d = ST_MID_DLY;
                    else if (need_last_dly && LAST_BEAT == '0)  state_d = ST_LAST_DLY;
                    else                                        state_d = ST_CD;
                end
            end
            ST_MID_DLY, ST_LAST_DLY: begin
                if (dly_done) begin
                    dly_cnt_d = '0;
                    state_d   = ST_CD;
                end else begin
                    dly_cnt_d = dly_cnt_q + 64'd1;
                end
            end
            ST_CD: begin
                o_cdvalid = 1'b1;
                o_cdlast  = (beat_q == LAST_BEAT);
                o_cddata  = {NW{beat_word}};
                if (i_cdready) begin
                    if (beat_q == LAST_BEAT) begin
                        state_d = ST_END;
                    end else begin
                        beat_d = beat_q + BW'(1);
                        // The final beat is held back when the last-beat delay is armed
                        if (need_last_dly && (beat_q + BW'(1) == LAST_BEAT)) state_d = ST_LAST_DLY;
                    end
                end
            end
            ST_END:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign cnt_inc = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
    assign nshot_n = (i_count_reg == '0) ? C_S_AXI_DATA_WIDTH'(1) : i_count_reg;

    always_comb begin
        done_set = 1'b0;
        case (ctrl_mode)
            MODE_OSH:   done_set = 1'b1;
            MODE_NSHOT: done_set = (C_S_AXI_DATA_WIDTH'(cnt_inc) == nshot_n);
            MODE_CON:   done_set = 1'b0;
            default:    done_set = 1'b0;
        endcase
    end

    always_ff @(posedge ace_aclk) begin
        if (ace_areset) begin
            state_q   <= ST_IDLE;
            dly_cnt_q <= '0;
            beat_q    <= '0;
            test_q    <= '0;
            crresp_q  <= '0;
            delay_q   <= '0;
            payload_q <= '0;
            done_q    <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            dly_cnt_q <= dly_cnt_d;
            beat_q    <= beat_d;
            // Shadow copies make mid-burst control writes apply to the next injection
            if (hit) begin
                test_q    <= ctrl_test;
                crresp_q  <= ctrl_crresp;
                delay_q   <= i_delay_reg;
                payload_q <= i_payload_reg;
            end
            if (state_q == ST_IDLE && (ctrl_clr || !ctrl_en)) begin
                done_q <= 1'b0;
                cnt_q  <= '0;
            end else if (state_q == ST_END) begin
                cnt_q <= cnt_inc;
                if (done_set) done_q <= 1'b1;
            end
        end
    end

    assign o_hit        = (state_q != ST_IDLE);
    assign o_state      = state_q;
    assign o_status_reg = C_S_AXI_DATA_WIDTH'({cnt_q, 14'b0, o_hit, done_q});

endmodule

// File: tb/tb_devil_snoop_injector.sv
// Randomized scoreboard bench for devil_snoop_injector: a spec-level model queues
// expected CR/CD responses, a monitor pops them on each handshake.
module tb_devil_snoop_injector;
    import devil_pkg::*;

    localparam int AW  = 44;
    localparam int DW  = 128;
    localparam int NB  = 4;
    localparam int CPU = 150;

    logic              clk, rst;
    logic              snoop_req;
    logic [AW-1:0]     acaddr;
    logic [3:0]        acsnoop;
    logic [31:0]       ctrl, dly, cnt_reg, payload;
    logic [AW-1:0]     win_base [4];
    logic [AW-1:0]     win_size [4];
    logic [4*AW-1:0]   base_flat, size_flat;
    logic [31:0]       status;
    logic              hit, crvalid, crready, cdvalid, cdlast, cdready;
    logic [3:0]        state;
    logic [4:0]        crresp;
    logic [DW-1:0]     cddata;

    assign base_flat = {win_base[3], win_base[2], win_base[1], win_base[0]};
    assign size_flat = {win_size[3], win_size[2], win_size[1], win_size[0]};

    devil_snoop_injector #(
        .C_S_AXI_DATA_WIDTH(32), .C_ACE_DATA_WIDTH(DW), .C_ACE_ADDR_WIDTH(AW),
        .NUM_WINDOWS(4), .CD_BEATS(NB), .CYCLES_PER_US(CPU)
    ) dut (
        .ace_aclk(clk), .ace_areset(rst), .i_snoop_req(snoop_req), .i_acaddr(acaddr),
        .i_acsnoop(acsnoop), .i_control_reg(ctrl), .i_delay_reg(dly), .i_count_reg(cnt_reg),
        .i_payload_reg(payload), .i_base_addr_flat(base_flat), .i_addr_size_flat(size_flat),
        .o_status_reg(status), .o_hit(hit), .o_state(state), .o_crresp(crresp),
        .o_crvalid(crvalid), .i_crready(crready), .o_cddata(cddata), .o_cdvalid(cdvalid),
        .o_cdlast(cdlast), .i_cdready(cdready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_chk  = 0;
    int n_pass = 0;
    int rdy_mode = 0;
    int cr_hold  = 0;
    logic [4:0]  cr_q [$];
    logic [DW:0] cd_q [$];
    logic        m_done  = 1'b0;
    logic [15:0] m_count = '0;

    task automatic chk(input string nm, input logic [191:0] act, input logic [191:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic timeout(input string nm);
        n_chk++;
        $display("FAIL %s: timed out waiting for DUT", nm);
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] mk_ctrl(bit en, logic [1:0] md, logic [2:0] tst, logic [4:0] cr,
                                            bit af, bit sf, logic [3:0] sm, bit clr);
        logic [31:0] v;
        v = '0;
        v[0] = en; v[2:1] = md; v[5:3] = tst; v[10:6] = cr;
        v[11] = af; v[12] = sf; v[16:13] = sm; v[17] = clr;
        return v;
    endfunction

    function automatic bit model_win(logic [AW-1:0] a);
        for (int w = 0; w < 4; w++) begin
            longint unsigned b, s, x;
            b = 64'(win_base[w]); s = 64'(win_size[w]); x = 64'(a);
            if (s != 0 && x >= b && x < b + s) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic bit model_hit(logic [AW-1:0] a, logic [3:0] s);
        if (!ctrl[0] || ctrl[2:1] == 2'd3 || m_done || ctrl[17]) return 1'b0;
        if (ctrl[11] && !model_win(a)) return 1'b0;
        if (ctrl[12] && s != ctrl[16:13]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_take();
        logic [4:0]  cr;
        logic [31:0] w, nmax;
        cr = ctrl[10:6];
        cr_q.push_back(cr);
        if (cr[0]) begin
            for (int k = 0; k < NB; k++) begin
                w = payload + 32'(k);
                cd_q.push_back({(k == NB - 1) ? 1'b1 : 1'b0, {4{w}}});
            end
        end
        if (m_count != 16'hFFFF) m_count = m_count + 16'd1;
        nmax = (cnt_reg == 0) ? 32'd1 : cnt_reg;
        if (ctrl[2:1] == MODE_OSH) m_done = 1'b1;
        else if (ctrl[2:1] == MODE_NSHOT && {16'b0, m_count} == nmax) m_done = 1'b1;
    endtask

    // ---------------- ready driver ----------------
    initial begin
        crready = 1'b1;
        cdready = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (cr_hold > 0) begin
                crready = 1'b0;
                cr_hold--;
            end else begin
                crready = (rdy_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            end
            cdready = (rdy_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        end
    end

    // ---------------- monitor / scoreboard ----------------
    logic        cr_stall = 1'b0, cd_stall = 1'b0;
    logic [4:0]  cr_prev;
    logic [DW:0] cd_prev;
    logic [4:0]  cr_e;
    logic [DW:0] cd_e;

    always @(negedge clk) begin
        if (rst) begin
            cr_stall = 1'b0;
            cd_stall = 1'b0;
        end else begin
            if (cr_stall) begin
                chk("cr_hold_valid", crvalid, 1'b1);
                chk("cr_hold_resp", crresp, cr_prev);
            end
            if (cd_stall) chk("cd_hold", {cdvalid, cdlast, cddata}, {1'b1, cd_prev});
            if (crvalid && crready) begin
                if (cr_q.size() == 0) timeout("cr_unexpected");
                else begin cr_e = cr_q.pop_front(); chk("crresp", crresp, cr_e); end
            end
            if (cdvalid && cdready) begin
                if (cd_q.size() == 0) timeout("cd_unexpected");
                else begin cd_e = cd_q.pop_front(); chk("cd_beat", {cdlast, cddata}, cd_e); end
            end
            cr_stall = crvalid && !crready;
            cr_prev  = crresp;
            cd_stall = cdvalid && !cdready;
            cd_prev  = {cdlast, cddata};
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_ctrl(input logic [31:0] v);
        @(posedge clk); #1;
        ctrl = v;
        if (!v[0] || v[17]) begin m_done = 1'b0; m_count = '0; end
    endtask

    task automatic snoop(input logic [AW-1:0] a, input logic [3:0] s, input string nm, output int lat);
        bit e;
        int n;
        e = model_hit(a, s);
        if (e) model_take();
        @(posedge clk); #1;
        snoop_req = 1'b1; acaddr = a; acsnoop = s;
        @(posedge clk); #1;
        snoop_req = 1'b0;
        @(negedge clk);
        chk({nm, "_hit"}, hit, e);
        lat = 0;
        if (e) begin
            n = 1;
            while (!crvalid && n < 2000) begin @(negedge clk); n++; end
            if (!crvalid) timeout({nm, "_cr"});
            else lat = n;
        end
    endtask

    task automatic wait_idle(input string nm);
        int n;
        n = 0;
        @(negedge clk);
        while (hit && n < 5000) begin @(negedge clk); n++; end
        if (hit) timeout(nm);
    endtask

    task automatic chk_status(input string nm);
        @(negedge clk);
        chk(nm, status, {m_count, 14'b0, 1'b0, m_done});
    endtask

    task automatic measure_gap(input int exp_gap);
        int hs, gap, n;
        hs = 0; gap = 0; n = 0;
        while (hs < NB - 1 && n < 5000) begin
            @(negedge clk); n++;
            if (cdvalid && cdready) hs++;
        end
        while (n < 5000) begin
            @(negedge clk); n++;
            if (cdvalid) break;
            gap++;
        end
        if (n >= 5000) timeout("t3_gap");
        else begin
            chk("t3_last_gap", gap, exp_gap);
            chk("t3_last_flag", cdlast, 1'b1);
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int lat;
        logic [AW-1:0] a;
        int off;
        rst = 1'b1; snoop_req = 1'b0; acaddr = '0; acsnoop = '0;
        ctrl = '0; dly = '0; cnt_reg = '0; payload = '0;
        for (int w = 0; w < 4; w++) begin win_base[w] = '0; win_size[w] = '0; end
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_status", status, 32'h0);
        chk("reset_ctl", {hit, crvalid, cdvalid, cdlast, state}, 8'h0);
        chk("reset_data", {crresp, cddata}, '0);
        @(posedge clk); #1 rst = 1'b0;

        // 1: one-shot, no filter
        payload = 32'hA0;
        set_ctrl(mk_ctrl(1, MODE_OSH, TEST_NONE, 5'b00001, 0, 0, 0, 0));
        snoop(44'(64'({$urandom, $urandom})), 4'h0, "t1", lat);
        chk("t1_cr_latency", lat, 1);
        wait_idle("t1_idle");
        chk_status("t1_status");
        snoop(44'h123, 4'h0, "t1_second", lat);
        chk_status("t1_status2");

        // 2: address windows, fixed then randomized
        win_base[0] = 44'h1000; win_size[0] = 44'h40;
        win_base[1] = 44'h2000; win_size[1] = 44'h0;
        set_ctrl(mk_ctrl(1, MODE_CON, TEST_NONE, 5'b00001, 1, 0, 0, 1));
        set_ctrl(mk_ctrl(1, MODE_CON, TEST_NONE, 5'b00001, 1, 0, 0, 0));
        snoop(44'h103F, 4'h0, "t2_top", lat);  wait_idle("t2_i0");
        snoop(44'h1000, 4'h0, "t2_base", lat); wait_idle("t2_i1");
        snoop(44'h0FFF, 4'h0, "t2_below", lat); wait_idle("t2_i2");
        snoop(44'h1040, 4'h0, "t2_end", lat);  wait_idle("t2_i3");
        snoop(44'h2000, 4'h0, "t2_dis", lat);  wait_idle("t2_i4");
        win_base[2] = 44'hFFF_FFFF_FFC0; win_size[2] = 44'h80;
        snoop(44'h0, 4'h0, "t2_nowrap", lat);  wait_idle("t2_i5");
        snoop(44'hFFF_FFFF_FFFF, 4'h0, "t2_top_win", lat); wait_idle("t2_i6");
        win_size[2] = '0;
        for (int i = 0; i < 12; i++) begin
            win_base[0] = 44'(64'({$urandom, $urandom}));
            win_size[0] = ($urandom_range(0, 3) == 0) ? 44'h0 : 44'($urandom_range(1, 512));
            off = $urandom_range(0, int'(win_size[0]) + 8) - 4;
            a = win_base[0] + 44'(off);
            payload = $urandom;
            set_ctrl(mk_ctrl(1, MODE_CON, TEST_NONE, 5'($urandom), 1, 0, 0, 0));
            snoop(a, 4'($urandom), "t2_rand", lat);
            wait_idle("t2_rand_idle");
        end
        set_ctrl(mk_ctrl(1, MODE_CON, TEST_NONE, 5'b00011, 0, 1, 4'h5, 0));
        snoop(44'h77, 4'h5, "t2_snp_match", lat); wait_idle("t2_i7");
        snoop(44'h77, 4'h3, "t2_snp_miss", lat);  wait_idle("t2_i8");

        // delays: pre-CR, pre-CD, both
        dly = 32'd1; payload = $urandom;
        set_ctrl(mk_ctrl(1, MODE_CON, TEST_DLY_CR, 5'b00001, 0, 0, 0, 0));
        snoop(44'h10, 4'h0, "d_cr", lat); chk("d_cr_latency", lat, 1 + CPU);
        wait_idle("d_cr_idle");
        set_ctrl(mk_ctrl(1, MODE_CON, TEST_DLY_CD, 5'b00101, 0, 0, 0, 0));
        snoop(44'h20, 4'h0, "d_cd", lat); chk("d_cd_latency", lat, 1);
        wait_idle("d_cd_idle");
        set_ctrl(mk_ctrl(1, MODE_CON, TEST_DLY_ALL, 5'b01001, 0, 0, 0, 0));
        snoop(44'h30, 4'h0, "d_all", lat); chk("d_all_latency", lat, 1 + CPU);
        wait_idle("d_all_idle");

        // 3: last-beat delay of 2 units
        dly = 32'd2; payload = $urandom;
        set_ctrl(mk_ctrl(1, MODE_CON, TEST_DLY_LAST, 5'b00001, 0, 0, 0, 0));
        snoop(44'h40, 4'h0, "t3", lat);
        measure_gap(2 * CPU);
        wait_idle("t3_idle");
        dly = 32'd0;

        // 4: backpressure on CR and CD
        rdy_mode = 1;
        for (int i = 0; i < 3; i++) begin
            payload = $urandom;
            set_ctrl(mk_ctrl(1, MODE_CON, TEST_NONE, {4'($urandom), 1'b1}, 0, 0, 0, 0));
            cr_hold = 7;
            snoop(44'h50, 4'h0, "t4", lat);
            wait_idle("t4_idle");
        end
        rdy_mode = 0;

        // 5: N-shot, clear, clear-vs-snoop priority, N=0
        cnt_reg = 32'd3;
        set_ctrl(mk_ctrl(1, MODE_NSHOT, TEST_NONE, 5'b00001, 0, 0, 0, 1));
        set_ctrl(mk_ctrl(1, MODE_NSHOT, TEST_NONE, 5'b00001, 0, 0, 0, 0));
        for (int i = 0; i < 3; i++) begin
            payload = $urandom;
            snoop(44'h60, 4'h0, "t5_shot", lat);
            wait_idle("t5_idle");
            chk_status("t5_status");
        end
        snoop(44'h60, 4'h0, "t5_after_done", lat);
        set_ctrl(mk_ctrl(1, MODE_NSHOT, TEST_NONE, 5'b00001, 0, 0, 0, 1));
        snoop(44'h60, 4'h0, "t5_during_clr", lat);
        chk_status("t5_cleared");
        set_ctrl(mk_ctrl(1, MODE_NSHOT, TEST_NONE, 5'b00001, 0, 0, 0, 0));
        snoop(44'h60, 4'h0, "t5_rehit", lat);
        wait_idle("t5_idle2");
        chk_status("t5_restart");
        cnt_reg = 32'd0;
        set_ctrl(mk_ctrl(1, MODE_NSHOT, TEST_NONE, 5'b00001, 0, 0, 0, 1));
        set_ctrl(mk_ctrl(1, MODE_NSHOT, TEST_NONE, 5'b00001, 0, 0, 0, 0));
        snoop(44'h60, 4'h0, "t5_n0", lat);
        wait_idle("t5_idle3");
        chk_status("t5_n0_status");

        // 6: reset during beat 1
        payload = $urandom;
        set_ctrl(mk_ctrl(1, MODE_OSH, TEST_NONE, 5'b00001, 0, 0, 0, 1));
        set_ctrl(mk_ctrl(1, MODE_OSH, TEST_NONE, 5'b00001, 0, 0, 0, 0));
        snoop(44'h70, 4'h0, "t6", lat);
        @(posedge clk);
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        chk("t6_in_beat1", {cdvalid, cddata}, {1'b1, {4{payload + 32'd1}}});
        @(negedge clk);
        chk("t6_reset_ctl", {hit, crvalid, cdvalid, cdlast, state}, 8'h0);
        chk("t6_reset_data", {status, crresp, cddata}, '0);
        cr_q.delete(); cd_q.delete();
        m_done = 1'b0; m_count = '0;
        @(posedge clk); #1 rst = 1'b0;
        payload = $urandom;
        snoop(44'h70, 4'h0, "t6_fresh", lat);
        wait_idle("t6_idle");
        chk_status("t6_status");

        repeat (3) @(negedge clk);
        chk("sb_cr_empty", cr_q.size(), 0);
        chk("sb_cd_empty", cd_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
